// File: rtl/pet_memmap_if.sv
// CPU-side bus bundle for the PET memory-map decoder: CPU request, the decoded
// strobes and addresses for RAM/VRAM/ROM/IO, and read data coming back.
interface pet_memmap_if #(
  parameter int VRAM_AW = 10
);
  // CPU request
  logic               ce_1m;
  logic [15:0]        addr;
  logic [7:0]         data_in;
  logic               we;
  logic [7:0]         data_out;
  // Target selects and addresses
  logic [16:0]        ram_addr;
  logic               ram_we;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_we;
  logic [14:0]        rom_addr;
  logic               io_cs;
  // Read data returned by the targets
  logic [7:0]         ram_q;
  logic [7:0]         vram_q;
  logic [7:0]         rom_q;
  logic [7:0]         io_q;
  // Banking control register (status/debug)
  logic [7:0]         ctrl;

  // CPU / system side: drives the request and the target read data
  modport master (
    output ce_1m, addr, data_in, we, ram_q, vram_q, rom_q, io_q,
    input  data_out, ram_addr, ram_we, vram_addr, vram_we, rom_addr, io_cs, ctrl
  );

  // Decoder side
  modport slave (
    input  ce_1m, addr, data_in, we, ram_q, vram_q, rom_q, io_q,
    output data_out, ram_addr, ram_we, vram_addr, vram_we, rom_addr, io_cs, ctrl
  );
endinterface

// File: rtl/pet_memmap.sv
// PET address decoder and read-data mux. Decodes the 6502 address into
// RAM / VRAM / ROM / IO / open bus, optionally banks 64 KB of expansion RAM
// over $8000-$FFFF (8096 style) under control of a write-only register at
// $FFF0, and registers the read select so data_out lines up with the one
// clock read latency of the synchronous memories.
module pet_memmap #(
  parameter int RAM_KB  = 32,   // base RAM size in KB (8/16/32)
  parameter int VRAM_AW = 10,   // 10 = 1 KB (40 col), 11 = 2 KB (80 col)
  parameter int EXT_RAM = 0     // 1 = $FFF0 control register + expansion RAM
) (
  input  logic         clk,
  input  logic         reset,
  pet_memmap_if.slave  bus
);

  typedef enum logic [2:0] {
    R_OPEN = 3'd0,
    R_RAM  = 3'd1,
    R_VRAM = 3'd2,
    R_ROM  = 3'd3,
    R_IO   = 3'd4
  } region_t;

  // First address above base RAM ($8000 for 32 KB)
  localparam logic [16:0] RAM_TOP = 17'(RAM_KB * 1024);

  logic [7:0] ctrl_q;
  logic [7:0] ctrl_d;
  region_t    region_d;
  region_t    sel_q;
  logic [7:0] hi_q;
  logic       exp_d;       // access lands in expansion RAM
  logic       prot_d;      // expansion write-protect for this half
  logic       bank_d;      // expansion bank bit for this half
  logic       wr_cycle;    // a CPU write actually happens this clock
  logic       ctrl_wr;     // this write targets the control register
  logic       ext_on;

  logic       is_io;
  logic       is_vram_win;
  logic       is_io_win;

  // Writes are dropped while reset is asserted so a reset mid-access never
  // lets a stray strobe through.
  assign wr_cycle    = bus.we & bus.ce_1m & ~reset;
  assign ext_on      = (EXT_RAM != 0) && ctrl_q[7];
  assign is_io       = (bus.addr[15:8] == 8'hE8);
  assign is_vram_win = (bus.addr[15:12] == 4'h8);
  assign is_io_win   = (bus.addr[15:11] == 5'b11101);   // $E800-$EFFF
  assign ctrl_wr     = (EXT_RAM != 0) && wr_cycle && (bus.addr == 16'hFFF0);

  // Region decode; banking mode only reshapes the upper 32 KB
  always_comb begin
    region_d = R_OPEN;
    exp_d    = 1'b0;
    if (ext_on && bus.addr[15]) begin
      if (ctrl_q[5] && is_vram_win) begin
        region_d = R_VRAM;
      end else if (ctrl_q[6] && is_io_win) begin
        region_d = is_io ? R_IO : R_ROM;
      end else begin
        region_d = R_RAM;
        exp_d    = 1'b1;
      end
    end else if (is_io) begin
      region_d = R_IO;
    end else if (is_vram_win) begin
      region_d = R_VRAM;
    end else if (bus.addr[15]) begin
      region_d = R_ROM;
    end else if ({1'b0, bus.addr} < RAM_TOP) begin
      region_d = R_RAM;
    end
  end

  // $8000-$BFFF uses bank/protect bits 2/0, $C000-$FFFF uses bits 3/1
  assign bank_d = bus.addr[14] ? ctrl_q[3] : ctrl_q[2];
  assign prot_d = exp_d & (bus.addr[14] ? ctrl_q[1] : ctrl_q[0]);

  assign bus.ram_addr  = exp_d ? {1'b1, bank_d, bus.addr[14:0]}
                               : {2'b00, bus.addr[14:0]};
  assign bus.ram_we    = wr_cycle & (region_d == R_RAM) & ~prot_d & ~ctrl_wr;
  assign bus.vram_addr = bus.addr[VRAM_AW-1:0];
  assign bus.vram_we   = wr_cycle & (region_d == R_VRAM);
  assign bus.rom_addr  = bus.addr[14:0];
  assign bus.io_cs     = (region_d == R_IO);
  assign bus.ctrl      = ctrl_q;

  assign ctrl_d = ctrl_wr ? bus.data_in : ctrl_q;

  generate
    if (EXT_RAM != 0) begin : g_ctrl
      // Banking control register; the new map applies from the next access
      always_ff @(posedge clk) begin
        if (reset) begin
          ctrl_q <= 8'h00;
        end else begin
          ctrl_q <= ctrl_d;
        end
      end
    end else begin : g_no_ctrl
      assign ctrl_q = 8'h00;
    end
  endgenerate

  // Register the read select and the open-bus byte to match memory latency
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= R_OPEN;
      hi_q  <= 8'h00;
    end else begin
      sel_q <= region_d;
      hi_q  <= bus.addr[15:8];
    end
  end

  // Read-data mux driven by the registered select
  always_comb begin
    bus.data_out = hi_q;
    case (sel_q)
      R_RAM:   bus.data_out = bus.ram_q;
      R_VRAM:  bus.data_out = bus.vram_q;
      R_ROM:   bus.data_out = bus.rom_q;
      R_IO:    bus.data_out = bus.io_q;
      default: bus.data_out = hi_q;
    endcase
  end

endmodule

// File: tb/tb_pet_memmap.sv
// Directed bench for pet_memmap. Two instances share one CPU bus:
//   dut_a: RAM_KB=16, no expansion; dut_b: RAM_KB=32 with expansion RAM.
// Each target returns a distinct constant byte so data_out identifies the
// region selected on the previous clock.
module tb_pet_memmap;

  localparam logic [7:0] RAM_Q  = 8'hA1;
  localparam logic [7:0] VRAM_Q = 8'hB2;
  localparam logic [7:0] ROM_Q  = 8'hC3;
  localparam logic [7:0] IO_Q   = 8'hD4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1m;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pet_memmap_if #(.VRAM_AW(10)) bus_a ();
  pet_memmap_if #(.VRAM_AW(10)) bus_b ();

  assign bus_a.ce_1m = ce_1m;   assign bus_b.ce_1m = ce_1m;
  assign bus_a.addr = addr;     assign bus_b.addr = addr;
  assign bus_a.data_in = data_in; assign bus_b.data_in = data_in;
  assign bus_a.we = we;         assign bus_b.we = we;
  assign bus_a.ram_q = RAM_Q;   assign bus_b.ram_q = RAM_Q;
  assign bus_a.vram_q = VRAM_Q; assign bus_b.vram_q = VRAM_Q;
  assign bus_a.rom_q = ROM_Q;   assign bus_b.rom_q = ROM_Q;
  assign bus_a.io_q = IO_Q;     assign bus_b.io_q = IO_Q;

  pet_memmap #(.RAM_KB(16), .VRAM_AW(10), .EXT_RAM(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  pet_memmap #(.RAM_KB(32), .VRAM_AW(10), .EXT_RAM(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a CPU access; combinational outputs settle before sampling
  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    addr    = a;
    we      = w;
    data_in = d;
    #1;
  endtask

  // Write the banking control register of dut_b (one clock)
  task automatic set_ctrl(input logic [7:0] v);
    drive(16'hFFF0, 1'b1, v);
    step();
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_1m = 1'b1; addr = 16'h0000; data_in = 8'h00; we = 1'b0;

    // 1: reset state
    step();
    check("rst_dout_a", 32'(bus_a.data_out), 32'h00);
    check("rst_dout_b", 32'(bus_b.data_out), 32'h00);
    check("rst_ctrl_b", 32'(bus_b.ctrl), 32'h00);
    reset = 1'b0;

    // 2: 16 KB base RAM, $4123 is open bus on dut_a, RAM on dut_b
    drive(16'h4123, 1'b0, 8'h00);
    step();
    check("open_bus_a", 32'(bus_a.data_out), 32'h41);
    check("ram32_rd_b", 32'(bus_b.data_out), 32'(RAM_Q));
    drive(16'h4123, 1'b1, 8'h55);
    check("open_we_a", 32'(bus_a.ram_we), 32'h0);
    check("ram32_we_b", 32'(bus_b.ram_we), 32'h1);
    check("ram32_addr_b", 32'(bus_b.ram_addr), 32'h04123);

    // Plain map reads on dut_a: RAM, ROM, IO
    drive(16'h2000, 1'b0, 8'h00);
    step();
    check("ram_rd_a", 32'(bus_a.data_out), 32'(RAM_Q));
    drive(16'h9000, 1'b0, 8'h00);
    step();
    check("rom_rd_a", 32'(bus_a.data_out), 32'(ROM_Q));
    drive(16'hE810, 1'b0, 8'h00);
    check("io_cs_a", 32'(bus_a.io_cs), 32'h1);
    step();
    check("io_rd_a", 32'(bus_a.data_out), 32'(IO_Q));

    // VRAM mirror, ce_1m gating, ROM write ignored
    drive(16'h8400, 1'b1, 8'h20);
    check("vram_addr_a", 32'(bus_a.vram_addr), 32'h000);
    check("vram_we_a", 32'(bus_a.vram_we), 32'h1);
    ce_1m = 1'b0; #1;
    check("vram_we_noce", 32'(bus_a.vram_we), 32'h0);
    ce_1m = 1'b1;
    drive(16'h9000, 1'b1, 8'h20);
    check("rom_wr_ram_we", 32'(bus_a.ram_we), 32'h0);
    check("rom_wr_vram_we", 32'(bus_a.vram_we), 32'h0);

    // $FFF0 write: dut_a has no register; same-edge read uses the old map
    drive(16'hFFF0, 1'b1, 8'h80);
    check("fff0_ram_we_b", 32'(bus_b.ram_we), 32'h0);
    step();
    we = 1'b0;
    check("ctrl_a_tied", 32'(bus_a.ctrl), 32'h00);
    check("ctrl_b_80", 32'(bus_b.ctrl), 32'h80);
    check("old_map_rd_b", 32'(bus_b.data_out), 32'(ROM_Q));

    // 3: expansion RAM banking in $C000-$FFFF
    drive(16'hC000, 1'b1, 8'h11);
    check("exp_addr_80", 32'(bus_b.ram_addr), 32'h14000);
    check("exp_we_80", 32'(bus_b.ram_we), 32'h1);
    step();
    set_ctrl(8'h88);
    drive(16'hC000, 1'b1, 8'h11);
    check("exp_addr_88", 32'(bus_b.ram_addr), 32'h1C000);

    // 4: write protect of the upper half only
    step();
    set_ctrl(8'h82);
    drive(16'hC010, 1'b1, 8'h22);
    check("prot_hi_we", 32'(bus_b.ram_we), 32'h0);
    drive(16'h8010, 1'b1, 8'h22);
    check("unprot_lo_we", 32'(bus_b.ram_we), 32'h1);
    check("unprot_lo_addr", 32'(bus_b.ram_addr), 32'h10010);
    check("exp_no_vram_we", 32'(bus_b.vram_we), 32'h0);
    drive(16'h8010, 1'b0, 8'h00);
    step();
    check("exp_rd_8010", 32'(bus_b.data_out), 32'(RAM_Q));

    // 5: VRAM window kept, then IO window kept
    set_ctrl(8'hA0);
    drive(16'h8005, 1'b1, 8'h33);
    check("keep_vram_we", 32'(bus_b.vram_we), 32'h1);
    check("keep_vram_ramwe", 32'(bus_b.ram_we), 32'h0);
    drive(16'hE810, 1'b0, 8'h00);
    check("io_banked_out", 32'(bus_b.io_cs), 32'h0);
    step();
    set_ctrl(8'hC0);
    drive(16'hE810, 1'b0, 8'h00);
    check("keep_io_cs", 32'(bus_b.io_cs), 32'h1);
    step();
    check("keep_io_rd", 32'(bus_b.data_out), 32'(IO_Q));
    drive(16'hE900, 1'b0, 8'h00);
    step();
    check("keep_rom_e9", 32'(bus_b.data_out), 32'(ROM_Q));
    drive(16'h8005, 1'b0, 8'h00);
    step();
    check("vram_banked_rd", 32'(bus_b.data_out), 32'(RAM_Q));

    // 6: reset clears banking and masks writes
    set_ctrl(8'h80);
    drive(16'hC000, 1'b0, 8'h00);
    step();
    check("banked_c000_rd", 32'(bus_b.data_out), 32'(RAM_Q));
    reset = 1'b1;
    drive(16'h0000, 1'b1, 8'h44);
    check("rst_ram_we_mask", 32'(bus_b.ram_we), 32'h0);
    step();
    check("rst2_ctrl_b", 32'(bus_b.ctrl), 32'h00);
    check("rst2_dout_b", 32'(bus_b.data_out), 32'h00);
    reset = 1'b0;
    drive(16'hC000, 1'b0, 8'h00);
    step();
    check("post_rst_rom", 32'(bus_b.data_out), 32'(ROM_Q));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on run time in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
